// File: rtl/usr_shift_reg.sv
// usr_shift_reg: WIDTH-bit universal shift register with hold/load/shift/rotate/ashr/clear modes
// and a multi-cycle "shift by N" sequencer using a start/busy/done handshake.
// Optional build macro USR_SHIFT_PARITY_EN adds a q_par output (XOR-reduce of q).
module usr_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
`ifdef USR_SHIFT_PARITY_EN
  ,
  output logic             q_par
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_ASHR  = 3'b110;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         mode_q, mode_d;
  logic               done_q, done_d;

  // One step of the selected operation applied to the current contents.
  function automatic logic [WIDTH-1:0] step_fn(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             in_msb,
    input logic             in_lsb
  );
    logic [WIDTH-1:0] res;
    case (op)
      M_HOLD:  res = cur;
      M_LOAD:  res = ld;
      M_SHL:   res = {cur[WIDTH-2:0], in_lsb};
      M_SHR:   res = {in_msb, cur[WIDTH-1:1]};
      M_ROTL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROTR:  res = {cur[0], cur[WIDTH-1:1]};
      M_ASHR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Only the shifting/rotating modes are worth sequencing over multiple cycles.
  function automatic logic is_multi(input logic [2:0] op);
    return (op >= M_SHL) && (op <= M_ASHR);
  endfunction

  // State and datapath registers; reset wins over everything, en=0 freezes via next-state logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= M_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Next-state: single steps in IDLE, latched-mode steps in RUN, done raised with the last step.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (start && is_multi(mode) && (amt != '0)) begin
            mode_d = mode;
            data_d = step_fn(mode, data_q, d, sin_l, sin_r);
            if (amt == AMT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              cnt_d   = amt - AMT_W'(1);
              state_d = S_RUN;
            end
          end else begin
            // A zero-length shift request degenerates to hold but still completes.
            data_d = (start && is_multi(mode)) ? data_q
                                               : step_fn(mode, data_q, d, sin_l, sin_r);
            done_d = start;
          end
        end
        S_RUN: begin
          data_d = step_fn(mode_q, data_q, d, sin_l, sin_r);
          cnt_d  = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are straight decodes of the registers.
  always_comb begin
    q      = data_q;
    sout_l = data_q[WIDTH-1];
    sout_r = data_q[0];
    busy   = (state_q == S_RUN);
    done   = done_q;
`ifdef USR_SHIFT_PARITY_EN
    q_par  = ^data_q;
`endif
  end

endmodule

// File: tb/tb_usr_shift_reg.sv
module tb_usr_shift_reg;

  logic       clk = 1'b0;
  logic       rst, en, sin_l, sin_r, start;
  logic [2:0] mode;
  logic [7:0] d;
  logic [2:0] amt;
  logic [7:0] q;
  logic       sout_l, sout_r, busy, done;
`ifdef USR_SHIFT_PARITY_EN
  logic       q_par;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  usr_shift_reg #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .start(start), .amt(amt),
    .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
`ifdef USR_SHIFT_PARITY_EN
    , .q_par(q_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00;
    sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; amt = 3'd0;
    tick(); tick();
    chk3("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // Single-step load then shl with sin_r=1
    en = 1'b1; mode = 3'b001; d = 8'h96; tick();
    chk("load96", 32'(q), 32'h96);
    mode = 3'b010; sin_r = 1'b1; tick();
    chk3("shl", 8'h2D, 1'b0, 1'b0);
    chk("shl.sout_l", 32'(sout_l), 32'd0);
    chk("shl.sout_r", 32'(sout_r), 32'd1);
    sin_r = 1'b0;

    // rotl by 3 from 0x81; busy-time inputs must be ignored
    mode = 3'b001; d = 8'h81; tick();
    start = 1'b1; mode = 3'b100; amt = 3'd3; tick();
    chk3("rotl.e0", 8'h03, 1'b1, 1'b0);
    mode = 3'b111; d = 8'hFF; amt = 3'd5; tick();
    chk3("rotl.e1", 8'h06, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000; tick();
    chk3("rotl.e2", 8'h0C, 1'b0, 1'b1);
    tick();
    chk3("rotl.e3", 8'h0C, 1'b0, 1'b0);

    // ashr by 7 from 0x80 with a 2-cycle stall
    mode = 3'b001; d = 8'h80; tick();
    start = 1'b1; mode = 3'b110; amt = 3'd7; tick();
    chk3("ashr.e0", 8'hC0, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000; tick();
    en = 1'b0; tick(); tick();
    chk3("ashr.stall", 8'hE0, 1'b1, 1'b0);
    en = 1'b1; tick(); tick(); tick(); tick();
    chk3("ashr.e7", 8'hFE, 1'b1, 1'b0);
    tick();
    chk3("ashr.done", 8'hFF, 1'b0, 1'b1);

    // Zero-length shift request
    mode = 3'b001; d = 8'h3C; tick();
    start = 1'b1; mode = 3'b011; amt = 3'd0; sin_l = 1'b1; tick();
    chk3("amt0", 8'h3C, 1'b0, 1'b1);
    start = 1'b0; mode = 3'b000; sin_l = 1'b0; tick();
    chk3("amt0.after", 8'h3C, 1'b0, 1'b0);

    // Back-to-back: start accepted in the done cycle
    start = 1'b1; mode = 3'b001; d = 8'h81; amt = 3'd0; tick();
    chk3("b2b.load", 8'h81, 1'b0, 1'b1);
    mode = 3'b101; amt = 3'd2; tick();
    chk3("b2b.e0", 8'hC0, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000; tick();
    chk3("b2b.e1", 8'h60, 1'b0, 1'b1);
    tick();
    chk("b2b.done_low", 32'(done), 32'd0);

    // Reset while in RUN with q=0xA5
    mode = 3'b001; d = 8'h4B; tick();
    start = 1'b1; mode = 3'b101; amt = 3'd5; tick();
    chk3("prerst", 8'hA5, 1'b1, 1'b0);
`ifdef USR_SHIFT_PARITY_EN
    chk("parity", 32'(q_par), 32'd0);
`endif
    start = 1'b0; rst = 1'b1; tick();
    chk3("midrst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0; mode = 3'b000; tick();
    chk3("postrst", 8'h00, 1'b0, 1'b0);

    // amt==1 completes without entering RUN
    mode = 3'b001; d = 8'h5A; tick();
    start = 1'b1; mode = 3'b011; amt = 3'd1; sin_l = 1'b1; tick();
    chk3("amt1", 8'hAD, 1'b0, 1'b1);
    start = 1'b0; mode = 3'b000; tick();
    chk("amt1.done_low", 32'(done), 32'd0);

    // en=0 in IDLE freezes everything
    en = 1'b0; mode = 3'b111; tick();
    chk3("idle_en0", 8'hAD, 1'b0, 1'b0);

    // Rotate right 7 then 1 more returns the original value
    en = 1'b1; start = 1'b1; mode = 3'b101; amt = 3'd7;
    tick();
    start = 1'b0; mode = 3'b000;
    for (int i = 0; i < 6; i++) tick();
    mode = 3'b101; tick();
    chk("rot8", 32'(q), 32'hAD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/usr_shift_reg.md
Name: usr_shift_reg

Overview:
Parametrised universal shift register, successor to the single-bit D latch storage element. It generalises the latch to a WIDTH-bit edge-triggered register with hold, parallel load, shift, rotate, arithmetic-shift and clear modes. It also adds a multi-cycle "shift by N" sequencer with a start/busy/done handshake. Used as a general storage/serialiser primitive in sequential datapath examples.

Parameters:
WIDTH, 8, register width in bits (>=2)
AMT_W, 3, width of shift-amount input; max multi-cycle shift = 2^AMT_W-1 steps

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  global enable; 0 = hold/stall everything except rst
mode  input  3  operation select (see Behaviour)
d  input  WIDTH  parallel load data
sin_l  input  1  serial in at MSB for logical shift right
sin_r  input  1  serial in at LSB for shift left
start  input  1  request multi-cycle operation
amt  input  AMT_W  number of steps for multi-cycle op
q  output  WIDTH  register contents
sout_l  output  1  q[WIDTH-1] (combinational from q)
sout_r  output  1  q[0] (combinational from q)
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset is synchronous and active-high; single clock clk. On rst=1 at a clock edge: q=0, busy=0, done=0, step counter=0, FSM=IDLE. rst has priority over all inputs, including mid-operation.
- Mode encoding, one step:
  - 000 hold
  - 001 load q=d
  - 010 shl: q={q[W-2:0],sin_r}
  - 011 shr: q={sin_l,q[W-1:1]}
  - 100 rotl
  - 101 rotr
  - 110 ashr: q={q[W-1],q[W-1:1]}
  - 111 clear q=0
- FSM states: IDLE, RUN.
- IDLE, en=0: nothing changes; done=0.
- IDLE, en=1, start=0: execute one step of mode at the edge (1-cycle latency, q updated at the edge); done=0.
- IDLE, en=1, start=1, mode in {010..110}, amt>0:
  - Latch mode and amt.
  - Perform the first step at this edge.
  - Counter = amt-1, busy=1, go to RUN.
  - If amt==1: no RUN; stay IDLE, busy=0, done=1 next cycle.
- IDLE, en=1, start=1, amt==0 or mode in {000,001,111}: execute one step of mode (hold for amt==0 with shift modes, i.e. q unchanged); done=1 in the following cycle; busy stays 0.
- RUN:
  - Each edge with en=1: one step of the latched mode; counter decrements.
  - When counter reaches 0: return to IDLE, busy=0, done=1 for exactly one cycle.
  - en=0: stall, no step, counter and q hold.
  - mode, d, start and amt are ignored while busy.
  - sin_l and sin_r are sampled live every step.
- Total multi-cycle latency: start edge to done high = amt cycles with en held high.
- done is a registered 1-cycle pulse. A new start is accepted in the same cycle done is high, because the FSM is already IDLE.
- Shift by exactly WIDTH or more with shl/shr yields all serial-in bits. Rotate by WIDTH returns the original value.

Optional Feature:
USR_SHIFT_PARITY_EN
- Defined: adds output port q_par (1 bit) = XOR-reduce of q, combinational from q, 0 after reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- rst=1 one edge while in RUN with q=8'hA5 -> next cycle q=0, busy=0, done=0.
- WIDTH=8, en=1, start=0, mode=001 d=8'h96, then mode=010 sin_r=1 -> q=8'h96, then q=8'h2D.
- q=8'h81, start=1 mode=100 amt=3 -> busy high 2 cycles; q=8'h0C at the edge where busy falls; done=1 the following cycle only.
- q=8'h80, start=1 mode=110 amt=7; drop en for 2 cycles mid-run -> q=8'hFF; done asserted 9 cycles after start.
- start=1 mode=011 amt=0 with q=8'h3C -> q stays 8'h3C, busy never asserts, done=1 next cycle.
- Back-to-back: issue start (mode=101, amt=2) in the cycle done is high -> accepted; q=8'h81 -> 8'hC0 -> 8'h60.
